microprocessor_core: RTL and testbench

Small 8-bit accumulator processor that executes a byte-coded program from a 1024-byte program image presented in parallel on its input. It runs one instruction per clock while enabled, exposes the accumulator as `result`, and stops at the halt byte 0xFF. Instantiated by the system top as a self-contained compute engine; the program image is driven externally and never written by the block.

---
 rtl/microprocessor_core.sv | 216 +++++++++++++++++++++
 tb/tb_microprocessor_core.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/microprocessor_core.sv
// 8-bit accumulator processor executing a byte-coded program from a parallel 1024-byte image.
// Latency: one instruction per clock in RUN; operands are read combinationally, no fetch stall.
// Backpressure: enable low in RUN pauses all state; HALT is left only through rst.
module microprocessor_core (
    input  logic          clk,
    input  logic          rst,
    input  logic [8191:0] memory,
    input  logic          enable,
    output logic [7:0]    result,
    output logic          running
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LDI   = 8'h01;
    localparam logic [7:0] OP_ADDI  = 8'h02;
    localparam logic [7:0] OP_SUBI  = 8'h03;
    localparam logic [7:0] OP_ANDI  = 8'h04;
    localparam logic [7:0] OP_ORI   = 8'h05;
    localparam logic [7:0] OP_XORI  = 8'h06;
    localparam logic [7:0] OP_NOT   = 8'h07;
    localparam logic [7:0] OP_SHL   = 8'h08;
    localparam logic [7:0] OP_SHR   = 8'h09;
    localparam logic [7:0] OP_LDB   = 8'h10;
    localparam logic [7:0] OP_ADD   = 8'h11;
    localparam logic [7:0] OP_SUB   = 8'h12;
    localparam logic [7:0] OP_MOVAB = 8'h13;
    localparam logic [7:0] OP_MOVBA = 8'h14;
    localparam logic [7:0] OP_HLT   = 8'hFF;

    state_t      state, state_n;
    logic [9:0]  pc, pc_n;
    logic [7:0]  a, a_n;
    logic [7:0]  b, b_n;
    logic        z, z_n;
    logic        c, c_n;

    logic [9:0]  pc_p1;
    logic [9:0]  pc_p2;
    logic [7:0]  opcode;
    logic [7:0]  operand;
    logic [9:0]  jump_tgt;
    logic [8:0]  alu9;
    logic        a_wr;

    // PC arithmetic wraps naturally at 10 bits, so PC=1023 fetches its operand from address 0.
    assign pc_p1    = pc + 10'd1;
    assign pc_p2    = pc + 10'd2;
    assign opcode   = memory[{pc, 3'b000} +: 8];
    assign operand  = memory[{pc_p1, 3'b000} +: 8];
    assign jump_tgt = {opcode[1:0], operand};

    assign result  = a;
    assign running = (state == S_RUN);

    // Architectural state register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= 10'd0;
            a     <= 8'h00;
            b     <= 8'h00;
            z     <= 1'b0;
            c     <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            a     <= a_n;
            b     <= b_n;
            z     <= z_n;
            c     <= c_n;
        end
    end

    // Next-state: sequencing between IDLE/RUN/HALT and single-cycle instruction execution.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        a_n     = a;
        b_n     = b;
        z_n     = z;
        c_n     = c;
        alu9    = 9'd0;
        a_wr    = 1'b0;

        case (state)
            S_IDLE: begin
                // The start edge only enters RUN; the first instruction executes on the next edge.
                if (enable) begin
                    state_n = S_RUN;
                end
            end

            S_RUN: begin
                if (enable) begin
                    pc_n = pc_p1;
                    casez (opcode)
                        OP_NOP: begin
                            pc_n = pc_p1;
                        end
                        OP_LDI: begin
                            a_n  = operand;
                            a_wr = 1'b1;
                            pc_n = pc_p2;
                        end
                        OP_ADDI: begin
                            alu9 = {1'b0, a} + {1'b0, operand};
                            a_n  = alu9[7:0];
                            c_n  = alu9[8];
                            a_wr = 1'b1;
                            pc_n = pc_p2;
                        end
                        OP_SUBI: begin
                            // Bit 8 of the 9-bit difference is the borrow (A < k).
                            alu9 = {1'b0, a} - {1'b0, operand};
                            a_n  = alu9[7:0];
                            c_n  = alu9[8];
                            a_wr = 1'b1;
                            pc_n = pc_p2;
                        end
                        OP_ANDI: begin
                            a_n  = a & operand;
                            a_wr = 1'b1;
                            pc_n = pc_p2;
                        end
                        OP_ORI: begin
                            a_n  = a | operand;
                            a_wr = 1'b1;
                            pc_n = pc_p2;
                        end
                        OP_XORI: begin
                            a_n  = a ^ operand;
                            a_wr = 1'b1;
                            pc_n = pc_p2;
                        end
                        OP_NOT: begin
                            a_n  = ~a;
                            a_wr = 1'b1;
                        end
                        OP_SHL: begin
                            c_n  = a[7];
                            a_n  = {a[6:0], 1'b0};
                            a_wr = 1'b1;
                        end
                        OP_SHR: begin
                            c_n  = a[0];
                            a_n  = {1'b0, a[7:1]};
                            a_wr = 1'b1;
                        end
                        OP_LDB: begin
                            b_n  = operand;
                            pc_n = pc_p2;
                        end
                        OP_ADD: begin
                            alu9 = {1'b0, a} + {1'b0, b};
                            a_n  = alu9[7:0];
                            c_n  = alu9[8];
                            a_wr = 1'b1;
                        end
                        OP_SUB: begin
                            alu9 = {1'b0, a} - {1'b0, b};
                            a_n  = alu9[7:0];
                            c_n  = alu9[8];
                            a_wr = 1'b1;
                        end
                        OP_MOVAB: begin
                            b_n = a;
                        end
                        OP_MOVBA: begin
                            a_n  = b;
                            a_wr = 1'b1;
                        end
                        8'b0010_00??: begin
                            pc_n = jump_tgt;
                        end
                        8'b0010_01??: begin
                            pc_n = z ? jump_tgt : pc_p2;
                        end
                        8'b0010_10??: begin
                            pc_n = z ? pc_p2 : jump_tgt;
                        end
                        8'b0010_11??: begin
                            pc_n = c ? jump_tgt : pc_p2;
                        end
                        OP_HLT: begin
                            // PC stays on the halt byte.
                            pc_n    = pc;
                            state_n = S_HALT;
                        end
                        default: begin
                            // Unassigned opcodes behave as 1-byte NOPs.
                            pc_n = pc_p1;
                        end
                    endcase
                    if (a_wr) begin
                        z_n = (a_n == 8'h00);
                    end
                end
            end

            S_HALT: begin
                state_n = S_HALT;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_microprocessor_core.sv
module tb_microprocessor_core;

    logic          clk;
    logic          rst;
    logic [8191:0] memory;
    logic          enable;
    logic [7:0]    result;
    logic          running;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    string      name_q[$];

    microprocessor_core dut (
        .clk     (clk),
        .rst     (rst),
        .memory  (memory),
        .enable  (enable),
        .result  (result),
        .running (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: each expectation pushed for an edge is compared at the following falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [8:0] e;
            string      n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if ({result, running} !== e) begin
                failures++;
                $display("FAIL %s: result=%02h running=%0b, required result=%02h running=%0b",
                         n, result, running, e[8:1], e[0]);
            end
        end
    end

    // Advance one edge, then queue the outputs required after that edge.
    task automatic tick_exp(input logic [7:0] r, input logic run, input string n);
        @(posedge clk);
        exp_q.push_back({r, run});
        name_q.push_back(n);
        #1;
    endtask

    task automatic clear_mem();
        memory = {1024{8'hFF}};
    endtask

    task automatic put(input int addr, input logic [7:0] v);
        memory[8*addr +: 8] = v;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        tick_exp(8'h00, 1'b0, "reset_apply");
        rst = 1'b0;
    endtask

    task automatic load_countdown();
        clear_mem();
        put(0, 8'h01); put(1, 8'h03);
        put(2, 8'h03); put(3, 8'h01);
        put(4, 8'h28); put(5, 8'h02);
        put(6, 8'hFF);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        memory = '0;
        for (int i = 0; i < 1024; i++) memory[8*i +: 8] = 8'(i * 37 + 1);
        #1;

        // Reset with enable low: stays idle regardless of image.
        tick_exp(8'h00, 1'b0, "reset_0");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick_exp(8'h00, 1'b0, "idle_hold");

        // LDI 5, ADDI 3, HLT.
        do_reset();
        clear_mem();
        put(0, 8'h01); put(1, 8'h05); put(2, 8'h02); put(3, 8'h03); put(4, 8'hFF);
        enable = 1'b1;
        tick_exp(8'h00, 1'b1, "basic_start");
        tick_exp(8'h05, 1'b1, "basic_ldi");
        tick_exp(8'h08, 1'b1, "basic_addi");
        tick_exp(8'h08, 1'b0, "basic_hlt");
        tick_exp(8'h08, 1'b0, "basic_hold");
        enable = 1'b0;
        tick_exp(8'h08, 1'b0, "halt_en0");
        enable = 1'b1;
        tick_exp(8'h08, 1'b0, "halt_en1");

        // ADDI overflow sets C, JC taken to address 6.
        do_reset();
        clear_mem();
        put(0, 8'h01); put(1, 8'hFF); put(2, 8'h02); put(3, 8'h02);
        put(4, 8'h2C); put(5, 8'h06); put(6, 8'h00); put(7, 8'h01);
        put(8, 8'hAA); put(9, 8'hFF);
        enable = 1'b1;
        tick_exp(8'h00, 1'b1, "jc_start");
        tick_exp(8'hFF, 1'b1, "jc_ldi");
        tick_exp(8'h01, 1'b1, "jc_addi_ovf");
        tick_exp(8'h01, 1'b1, "jc_jump");
        tick_exp(8'h01, 1'b1, "jc_nop");
        tick_exp(8'hAA, 1'b1, "jc_ldi_aa");
        tick_exp(8'hAA, 1'b0, "jc_hlt");

        // Countdown loop driven by Z through JNZ.
        do_reset();
        load_countdown();
        enable = 1'b1;
        tick_exp(8'h00, 1'b1, "cd_start");
        tick_exp(8'h03, 1'b1, "cd_ldi");
        tick_exp(8'h02, 1'b1, "cd_sub1");
        tick_exp(8'h02, 1'b1, "cd_jnz1");
        tick_exp(8'h01, 1'b1, "cd_sub2");
        tick_exp(8'h01, 1'b1, "cd_jnz2");
        tick_exp(8'h00, 1'b1, "cd_sub3");
        tick_exp(8'h00, 1'b1, "cd_jnz_fall");
        tick_exp(8'h00, 1'b0, "cd_hlt");

        // Pause for four cycles mid-program, then resume.
        do_reset();
        load_countdown();
        enable = 1'b1;
        tick_exp(8'h00, 1'b1, "pz_start");
        tick_exp(8'h03, 1'b1, "pz_ldi");
        tick_exp(8'h02, 1'b1, "pz_sub1");
        enable = 1'b0;
        for (int i = 0; i < 4; i++) tick_exp(8'h02, 1'b1, "pz_paused");
        enable = 1'b1;
        tick_exp(8'h02, 1'b1, "pz_jnz1");
        tick_exp(8'h01, 1'b1, "pz_sub2");
        tick_exp(8'h01, 1'b1, "pz_jnz2");
        tick_exp(8'h00, 1'b1, "pz_sub3");
        tick_exp(8'h00, 1'b1, "pz_jnz_fall");
        tick_exp(8'h00, 1'b0, "pz_hlt");

        // Reset mid-run, then restart from address 0 with enable held high.
        do_reset();
        load_countdown();
        enable = 1'b1;
        tick_exp(8'h00, 1'b1, "mr_start");
        tick_exp(8'h03, 1'b1, "mr_ldi");
        tick_exp(8'h02, 1'b1, "mr_sub1");
        rst = 1'b1;
        tick_exp(8'h00, 1'b0, "mr_reset");
        rst = 1'b0;
        tick_exp(8'h00, 1'b1, "mr_restart");
        tick_exp(8'h03, 1'b1, "mr_ldi_again");

        // ALU, B register, flags and taken/not-taken branches.
        do_reset();
        clear_mem();
        put(0, 8'h01);  put(1, 8'h81);
        put(2, 8'h08);
        put(3, 8'h2C);  put(4, 8'h08);
        put(5, 8'h01);  put(6, 8'hEE);
        put(8, 8'h10);  put(9, 8'h05);
        put(10, 8'h11);
        put(11, 8'h12);
        put(12, 8'h12);
        put(13, 8'h07);
        put(14, 8'h09);
        put(15, 8'h06); put(16, 8'h0F);
        put(17, 8'h04); put(18, 8'h0C);
        put(19, 8'h05); put(20, 8'h30);
        put(21, 8'h13);
        put(22, 8'h01); put(23, 8'h00);
        put(24, 8'h24); put(25, 8'h1C);
        put(26, 8'h01); put(27, 8'hEE);
        put(28, 8'h14);
        put(29, 8'h55);
        enable = 1'b1;
        tick_exp(8'h00, 1'b1, "alu_start");
        tick_exp(8'h81, 1'b1, "alu_ldi");
        tick_exp(8'h02, 1'b1, "alu_shl");
        tick_exp(8'h02, 1'b1, "alu_jc");
        tick_exp(8'h02, 1'b1, "alu_ldb");
        tick_exp(8'h07, 1'b1, "alu_add");
        tick_exp(8'h02, 1'b1, "alu_sub");
        tick_exp(8'hFD, 1'b1, "alu_sub_wrap");
        tick_exp(8'h02, 1'b1, "alu_not");
        tick_exp(8'h01, 1'b1, "alu_shr");
        tick_exp(8'h0E, 1'b1, "alu_xori");
        tick_exp(8'h0C, 1'b1, "alu_andi");
        tick_exp(8'h3C, 1'b1, "alu_ori");
        tick_exp(8'h3C, 1'b1, "alu_movab");
        tick_exp(8'h00, 1'b1, "alu_ldi0");
        tick_exp(8'h00, 1'b1, "alu_jz");
        tick_exp(8'h3C, 1'b1, "alu_movba");
        tick_exp(8'h3C, 1'b1, "alu_undef_nop");
        tick_exp(8'h3C, 1'b0, "alu_hlt");

        // JMP to 0x3FF: LDI there takes its operand from address 0, PC wraps to 1.
        do_reset();
        clear_mem();
        put(0, 8'h23); put(1, 8'hFF);
        put(1023, 8'h01);
        enable = 1'b1;
        tick_exp(8'h00, 1'b1, "wrap_start");
        tick_exp(8'h00, 1'b1, "wrap_jmp");
        tick_exp(8'h23, 1'b1, "wrap_ldi");
        tick_exp(8'h23, 1'b0, "wrap_hlt");

        // Halt at address 0: running high for exactly one cycle.
        do_reset();
        clear_mem();
        enable = 1'b1;
        tick_exp(8'h00, 1'b1, "hlt0_start");
        tick_exp(8'h00, 1'b0, "hlt0_hlt");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
